apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

- APB completer (slave) that sits directly downstream of the APB master interface stage.
- Consumes `pclk`/`psel`/`paddr`/`penable`/`pwdata`/`pwrite` and returns `pready`/`prdata`/`pslverr`.
- Implements a bank of read/write registers with a programmable number of wait states, address-range checking and a one-cycle write notification for downstream logic.
- One instance is attached per `psel` bit of the master.

## Interface
- `DATA_WIDTH`, 16: data bus width (`pwdata`, `prdata`, registers).
- `ADDR_WIDTH`, 8: address bus width.
- `NUM_REGS`, 16: number of registers; legal word index 0..`NUM_REGS`-1, `NUM_REGS` ≤ 2^`ADDR_WIDTH`.
- `WAIT_CYCLES`, 1: wait states inserted in every access phase, 0..15.
- `clk`  in  1  one clock, driven by the master's `pclk`; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `psel`  in  1  select bit for this slave.
- `paddr`  in  `ADDR_WIDTH`  word index.
- `pwrite`  in  1  1 = write, 0 = read.
- `penable`  in  1  access-phase indicator.
- `pwdata`  in  `DATA_WIDTH`  write data.
- `pready`  out  1  transfer-complete.
- `prdata`  out  `DATA_WIDTH`  read data, valid when `pready`=1 and `pwrite`=0.
- `pslverr`  out  1  error response, valid only with `pready`.
- `wr_pulse`  out  1  one-cycle strobe after a committed write.
- `wr_idx`  out  `ADDR_WIDTH`  index of the last committed write.

## Operation
- **FSM states:**
  - **IDLE**
    - `psel`=1 and `penable`=0 → capture `paddr`/`pwrite`/`pwdata`.
    - Load wait counter with `WAIT_CYCLES`.
    - Load `prdata_q` with `regs[paddr]`, or 0 if out of range.
    - Flag error if `paddr` ≥ `NUM_REGS`.
    - Go to ACCESS.
    - `penable`=1 without a prior setup cycle is ignored.
  - **ACCESS**
    - `psel`=0 or `penable`=0 → protocol abort to IDLE; no write, no strobe.
    - Otherwise, counter ≠ 0 → decrement.
    - Counter = 0 → `pready` high. At that edge: commit the write (if `pwrite` and no error), then go to IDLE.
- `pready` = (state==ACCESS && counter==0); decoded from registers only, no combinational path from inputs.
- `prdata` = `prdata_q` while `pready`; 0 otherwise.
- `pslverr` = error flag while `pready`; 0 otherwise.
- **Out-of-range access:** `pslverr`=1, write dropped, `prdata`=0, `wr_pulse` stays 0.
- **Commit:**
  - `regs[idx]` ← captured `pwdata`.
  - `wr_pulse`=1 for exactly the next cycle.
  - `wr_idx` ← idx, held until the next commit.
- A read of a register returns the value of any write that completed in an earlier transfer.
- **Back-to-back:** a new setup in the cycle right after completion is accepted from IDLE with no bubble.
- **Reset:** any state → IDLE.
  - `pready`=0, `prdata`=0, `pslverr`=0, `wr_pulse`=0, `wr_idx`=0.
  - All registers 0, counter 0, error flag 0.
  - A reset during ACCESS discards the transfer; the register is unchanged.

## Timing
- Setup sampled at edge E0.
- `pready` rises after edge E0+`WAIT_CYCLES` and the master samples it at E0+`WAIT_CYCLES`+1.
- The access phase lasts `WAIT_CYCLES`+1 cycles; `WAIT_CYCLES`=0 gives a zero-wait transfer.
- `pready` is high for exactly one cycle per transfer.
- The write lands in `regs` at the completing edge.
- `wr_pulse` is high in the cycle after the completing edge.
- `prdata` is stable for the whole `pready` cycle.

## Structure
- **Shared package `apb_pkg`:**
  - FSM state encoding (IDLE, ACCESS).
  - Default `DATA_WIDTH`/`ADDR_WIDTH`.
  - The total slave count constant.
- **Sub-module `apb_reg_bank`:**
  - Register array with a write port (en, idx, data) and an asynchronous read port (idx → data).
  - Reset clears all entries.
- The top level keeps the FSM, wait counter, capture registers and response logic.

## Test plan
- **Reset:** assert `rst` mid-ACCESS with `WAIT_CYCLES`=3 → `pready`=0 immediately, no write committed, a subsequent read of that index returns 0x0000.
- **Write then read, `WAIT_CYCLES`=1:** write 0xA5C3 to idx 5 → `pready` high in the 2nd access cycle, `wr_pulse`=1 next cycle, `wr_idx`=5. Read idx 5 → `prdata`=0xA5C3, `pslverr`=0.
- **Zero wait (`WAIT_CYCLES`=0):** read idx 0 after reset → `pready` in the first access cycle, `prdata`=0x0000. Back-to-back write idx 1 = 0x1234 then read idx 1 with no idle gap → 0x1234.
- **Out of range (`NUM_REGS`=16):** write 0xFFFF to idx 20 → `pready`=1 with `pslverr`=1, `wr_pulse`=0. Read idx 20 → `prdata`=0, `pslverr`=1.
- **Protocol abort:** drop `psel` during the 2nd of 3 wait cycles on a write of 0x0F0F to idx 2 → no `pready`, FSM back to IDLE, idx 2 still reads its previous value.
- **Spurious enable:** `penable`=1 with `psel`=1 but no preceding setup cycle from IDLE → no transfer started, `pready` stays 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default bus widths and system-wide constants.
package apb_pkg;

    localparam int unsigned APB_DATA_WIDTH = 16;
    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_NUM_SLAVES = 4;
    localparam int unsigned APB_CNT_WIDTH  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Register array with one synchronous write port and one asynchronous read port.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned           IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_ok;
    logic                  rd_ok;

    // Out-of-range indices never alias onto a real entry.
    assign wr_ok = wr_en_i && ({1'b0, wr_idx_i} < LIMIT);
    assign rd_ok = ({1'b0, rd_idx_i} < LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_idx_i[IDX_W-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_ok) begin
            rd_data_o = regs_q[rd_idx_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank, programmable wait states, range checking
// and a one-cycle write notification.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  wr_pulse,
    output logic [ADDR_WIDTH-1:0] wr_idx
);

    localparam logic [ADDR_WIDTH:0]        LIMIT     = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [APB_CNT_WIDTH-1:0]   WAIT_LOAD = APB_CNT_WIDTH'(WAIT_CYCLES);

    apb_state_e              state_q,    state_d;
    logic [APB_CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic                    write_q,    write_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0]   prdata_q,   prdata_d;
    logic                    err_q,      err_d;
    logic                    wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]   wr_idx_q,   wr_idx_d;

    logic [DATA_WIDTH-1:0]   bank_rdata;
    logic                    last;
    logic                    commit;

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (commit),
        .wr_idx_i  (addr_q),
        .wr_data_i (wdata_q),
        .rd_idx_i  (paddr),
        .rd_data_o (bank_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            err_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    // Abort takes priority over completion, so a dropped psel/penable never commits.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        prdata_d   = prdata_q;
        err_d      = err_q;
        wr_pulse_d = commit;
        wr_idx_d   = commit ? addr_q : wr_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = WAIT_LOAD;
                    addr_d   = paddr;
                    write_d  = pwrite;
                    wdata_d  = pwdata;
                    prdata_d = bank_rdata;
                    err_d    = !({1'b0, paddr} < LIMIT);
                end
            end
            ST_ACCESS: begin
                if (!psel || !penable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        last     = (state_q == ST_ACCESS) && (cnt_q == '0);
        pready   = last;
        prdata   = last ? prdata_q : '0;
        pslverr  = last && err_q;
        commit   = last && psel && penable && write_q && !err_q;
        wr_pulse = wr_pulse_q;
        wr_idx   = wr_idx_q;
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers (0, 1 and 3 wait states) driven by directed transfers.
module tb_apb_slave_regfile;

    typedef struct packed {
        logic        chk_data;
        logic [15:0] rdata;
        logic        err;
        logic        pulse;
        logic [7:0]  idx;
    } exp_t;

    logic              clk = 1'b0;
    logic [2:0]        rst_v = 3'b111;
    logic [2:0]        psel_v = '0;
    logic [2:0]        pwrite_v = '0;
    logic [2:0]        penable_v = '0;
    logic [2:0][7:0]   paddr_v = '0;
    logic [2:0][15:0]  pwdata_v = '0;
    logic [2:0]        pready_v;
    logic [2:0][15:0]  prdata_v;
    logic [2:0]        pslverr_v;
    logic [2:0]        wr_pulse_v;
    logic [2:0][7:0]   wr_idx_v;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic pend [3] = '{1'b0, 1'b0, 1'b0};
    exp_t pend_e [3];

    always #5 clk = ~clk;

    apb_slave_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst_v[0]), .psel(psel_v[0]), .paddr(paddr_v[0]), .pwrite(pwrite_v[0]),
        .penable(penable_v[0]), .pwdata(pwdata_v[0]), .pready(pready_v[0]), .prdata(prdata_v[0]),
        .pslverr(pslverr_v[0]), .wr_pulse(wr_pulse_v[0]), .wr_idx(wr_idx_v[0]));

    apb_slave_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst_v[1]), .psel(psel_v[1]), .paddr(paddr_v[1]), .pwrite(pwrite_v[1]),
        .penable(penable_v[1]), .pwdata(pwdata_v[1]), .pready(pready_v[1]), .prdata(prdata_v[1]),
        .pslverr(pslverr_v[1]), .wr_pulse(wr_pulse_v[1]), .wr_idx(wr_idx_v[1]));

    apb_slave_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst_v[2]), .psel(psel_v[2]), .paddr(paddr_v[2]), .pwrite(pwrite_v[2]),
        .penable(penable_v[2]), .pwdata(pwdata_v[2]), .pready(pready_v[2]), .prdata(prdata_v[2]),
        .pslverr(pslverr_v[2]), .wr_pulse(wr_pulse_v[2]), .wr_idx(wr_idx_v[2]));

    function automatic int wait_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic exp_t mk(input logic cd, input logic [15:0] rd, input logic er,
                                input logic pu, input logic [7:0] ix);
        exp_t e;
        e.chk_data = cd;
        e.rdata    = rd;
        e.err      = er;
        e.pulse    = pu;
        e.idx      = ix;
        return e;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, i, act, exp);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop(input int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic mon_step(input int i);
        exp_t e;
        if (pend[i]) begin
            chk("wr_pulse", i, 32'(wr_pulse_v[i]), 32'(pend_e[i].pulse));
            chk("wr_idx", i, 32'(wr_idx_v[i]), 32'(pend_e[i].idx));
            pend[i] = 1'b0;
        end else begin
            chk("wr_pulse_quiet", i, 32'(wr_pulse_v[i]), 32'd0);
        end
        if (pready_v[i]) begin
            if (qsize(i) == 0) begin
                chk("unexpected_pready", i, 32'd1, 32'd0);
            end else begin
                pop(i, e);
                if (e.chk_data) chk("prdata", i, 32'(prdata_v[i]), 32'(e.rdata));
                chk("pslverr", i, 32'(pslverr_v[i]), 32'(e.err));
                pend[i]   = 1'b1;
                pend_e[i] = e;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon_step(i);
    end

    task automatic xfer(input int i, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input exp_t e);
        int   cyc;
        logic got;
        push(i, e);
        psel_v[i]    = 1'b1;
        penable_v[i] = 1'b0;
        pwrite_v[i]  = wr;
        paddr_v[i]   = a;
        pwdata_v[i]  = d;
        @(posedge clk);
        #1 penable_v[i] = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 32) begin
            @(negedge clk);
            cyc++;
            got = pready_v[i];
            @(posedge clk);
            #1;
        end
        chk("access_cycles", i, 32'(cyc), 32'(wait_of(i) + 1));
        psel_v[i]    = 1'b0;
        penable_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", i, 32'(pready_v[i]), 32'd0);
            chk("rst_prdata", i, 32'(prdata_v[i]), 32'd0);
            chk("rst_pslverr", i, 32'(pslverr_v[i]), 32'd0);
            chk("rst_wr_idx", i, 32'(wr_idx_v[i]), 32'd0);
        end
        @(posedge clk);
        #1 rst_v = 3'b000;
        idle(1);

        // one wait state: write, read back, then last legal index back-to-back
        xfer(1, 1'b1, 8'd5,  16'hA5C3, mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'd5));
        xfer(1, 1'b0, 8'd5,  16'h0000, mk(1'b1, 16'hA5C3, 1'b0, 1'b0, 8'd5));
        xfer(1, 1'b1, 8'd15, 16'h0001, mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'd15));
        xfer(1, 1'b0, 8'd15, 16'h0000, mk(1'b1, 16'h0001, 1'b0, 1'b0, 8'd15));
        idle(2);

        // zero wait: read after reset, back-to-back write/read, out-of-range
        xfer(0, 1'b0, 8'd0,  16'h0000, mk(1'b1, 16'h0000, 1'b0, 1'b0, 8'd0));
        xfer(0, 1'b1, 8'd1,  16'h1234, mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'd1));
        xfer(0, 1'b0, 8'd1,  16'h0000, mk(1'b1, 16'h1234, 1'b0, 1'b0, 8'd1));
        xfer(0, 1'b1, 8'd20, 16'hFFFF, mk(1'b1, 16'h0000, 1'b1, 1'b0, 8'd1));
        xfer(0, 1'b0, 8'd20, 16'h0000, mk(1'b1, 16'h0000, 1'b1, 1'b0, 8'd1));
        xfer(0, 1'b0, 8'd16, 16'h0000, mk(1'b1, 16'h0000, 1'b1, 1'b0, 8'd1));
        xfer(0, 1'b0, 8'd4,  16'h0000, mk(1'b1, 16'h0000, 1'b0, 1'b0, 8'd1));
        idle(2);

        // three wait states: establish a value, then abort a write over it
        xfer(2, 1'b1, 8'd2, 16'h1111, mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'd2));
        psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1;
        paddr_v[2] = 8'd2; pwdata_v[2] = 16'h0F0F;
        @(posedge clk);
        #1 penable_v[2] = 1'b1;
        @(posedge clk);
        #1 psel_v[2] = 1'b0; penable_v[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_pready", 2, 32'(pready_v[2]), 32'd0);
        end
        idle(1);
        xfer(2, 1'b0, 8'd2, 16'h0000, mk(1'b1, 16'h1111, 1'b0, 1'b0, 8'd2));
        idle(1);

        // reset in the middle of an access phase
        psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1;
        paddr_v[2] = 8'd7; pwdata_v[2] = 16'hBEEF;
        @(posedge clk);
        #1 penable_v[2] = 1'b1;
        @(posedge clk);
        #1 rst_v[2] = 1'b1;
        #1;
        chk("midrst_pready", 2, 32'(pready_v[2]), 32'd0);
        chk("midrst_wr_idx", 2, 32'(wr_idx_v[2]), 32'd0);
        psel_v[2] = 1'b0; penable_v[2] = 1'b0;
        idle(2);
        rst_v[2] = 1'b0;
        idle(1);
        xfer(2, 1'b0, 8'd7, 16'h0000, mk(1'b1, 16'h0000, 1'b0, 1'b0, 8'd0));
        xfer(2, 1'b0, 8'd2, 16'h0000, mk(1'b1, 16'h0000, 1'b0, 1'b0, 8'd0));
        idle(1);

        // enable without a setup cycle must not start a transfer
        psel_v[2] = 1'b1; penable_v[2] = 1'b1; pwrite_v[2] = 1'b1;
        paddr_v[2] = 8'd3; pwdata_v[2] = 16'hDEAD;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("spurious_no_pready", 2, 32'(pready_v[2]), 32'd0);
        end
        @(posedge clk);
        #1 psel_v[2] = 1'b0; penable_v[2] = 1'b0;
        idle(1);
        xfer(2, 1'b0, 8'd3, 16'h0000, mk(1'b1, 16'h0000, 1'b0, 1'b0, 8'd0));
        xfer(2, 1'b1, 8'd3, 16'h5A5A, mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'd3));
        xfer(2, 1'b0, 8'd3, 16'h0000, mk(1'b1, 16'h5A5A, 1'b0, 1'b0, 8'd3));
        idle(4);

        for (int i = 0; i < 3; i++) chk("scoreboard_drained", i, 32'(qsize(i)), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
